// File: rtl/regfile_arb_pkg.sv
// Shared constants for the register-file port arbiter: FSM encoding and default widths.
package regfile_arb_pkg;
  localparam logic [1:0] ST_INIT   = 2'd0;
  localparam logic [1:0] ST_ARB    = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam int DW_DEF = 16;
  localparam int AW_DEF = 4;
endpackage

// File: rtl/regfile_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo NREQ.
module rr_pick
  import regfile_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx,
  output logic            any
);
  always_comb begin
    logic [PW-1:0] cand;
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = PW'((int'(ptr) + k) % NREQ);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end
endmodule

// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter sharing one register-file port (2R/1W) among NREQ requesters, with
// post-reset clear sequence. Optional requester locking under `REGFILE_ARB_LOCK_EN.
module regfile_port_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = DW_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ*AW-1:0]   req_ra1,
  input  logic [NREQ*AW-1:0]   req_ra2,
  input  logic [NREQ*AW-1:0]   req_wa,
  input  logic [NREQ*DW-1:0]   req_wd,
`ifdef REGFILE_ARB_LOCK_EN
  input  logic [NREQ-1:0]      req_lock,
`endif
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      resp_valid,
  output logic [DW-1:0]        resp_d1,
  output logic [DW-1:0]        resp_d2,
  output logic [AW-1:0]        rf_re1,
  output logic [AW-1:0]        rf_re2,
  output logic [AW-1:0]        rf_w,
  output logic [DW-1:0]        rf_da,
  output logic                 rf_we,
  input  logic [DW-1:0]        rf_d1,
  input  logic [DW-1:0]        rf_d2,
  output logic                 init_done
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [1:0]      state;
  logic [AW-1:0]   init_cnt;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   next_ptr;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] gnt;
  logic            any;
  logic            do_wr;
  logic            do_rd;
  logic [AW-1:0]   re1_hold, re2_hold, w_hold;
  logic [DW-1:0]   da_hold;
  logic [NREQ-1:0] vld_p1;
  logic signed [DW-1:0] d1_p1, d2_p1;
`ifdef REGFILE_ARB_LOCK_EN
  logic [PW-1:0]   lock_owner;
`endif

  always_comb begin
    elig = '0;
    if (state == ST_ARB) begin
      elig = req_valid;
`ifdef REGFILE_ARB_LOCK_EN
    end else if (state == ST_LOCKED) begin
      elig = req_valid & (NREQ'(1) << lock_owner);
`endif
    end
  end

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req (elig),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (win_idx),
    .any (any)
  );

  assign do_wr     = any & req_we[win_idx];
  assign do_rd     = any & ~req_we[win_idx];
  assign next_ptr  = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
  assign req_ready = gnt;

  // Address/data buses keep their last driven value whenever nothing is granted.
  always_comb begin
    rf_we  = 1'b0;
    rf_w   = w_hold;
    rf_da  = da_hold;
    rf_re1 = re1_hold;
    rf_re2 = re2_hold;
    if (state == ST_INIT) begin
      rf_we = Rst;
      rf_w  = init_cnt;
      rf_da = '0;
    end else if (do_wr) begin
      rf_we = 1'b1;
      rf_w  = req_wa[win_idx*AW +: AW];
      rf_da = req_wd[win_idx*DW +: DW];
    end else if (do_rd) begin
      rf_re1 = req_ra1[win_idx*AW +: AW];
      rf_re2 = req_ra2[win_idx*AW +: AW];
    end
  end

  always_ff @(posedge Clk) begin
    re1_hold <= rf_re1;
    re2_hold <= rf_re2;
    w_hold   <= rf_w;
    da_hold  <= rf_da;
  end

  // p1: registered read response
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      vld_p1 <= '0;
      d1_p1  <= '0;
      d2_p1  <= '0;
    end else begin
      vld_p1 <= do_rd ? gnt : '0;
      if (do_rd) begin
        d1_p1 <= rf_d1;
        d2_p1 <= rf_d2;
      end
    end
  end

  assign resp_valid = vld_p1;
  assign resp_d1    = d1_p1;
  assign resp_d2    = d2_p1;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state      <= ST_INIT;
      init_cnt   <= '0;
      rr_ptr     <= '0;
      init_done  <= 1'b0;
`ifdef REGFILE_ARB_LOCK_EN
      lock_owner <= '0;
`endif
    end else begin
      case (state)
        ST_INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (&init_cnt) begin
            state     <= ST_ARB;
            init_done <= 1'b1;
          end
        end
        ST_ARB: begin
          if (any) begin
            rr_ptr <= next_ptr;
`ifdef REGFILE_ARB_LOCK_EN
            if (req_lock[win_idx]) begin
              state      <= ST_LOCKED;
              lock_owner <= win_idx;
            end
`endif
          end
        end
`ifdef REGFILE_ARB_LOCK_EN
        ST_LOCKED: begin
          if (any && !req_lock[win_idx]) state <= ST_ARB;
        end
`endif
        default: state <= ST_INIT;
      endcase
    end
  end
endmodule
